data_pipe_1ton: RTL and testbench
=================================

Name: data_pipe_1ton

Overview:
- Narrow-to-wide width converter on a single clock: collects NSIZE consecutive DSIZE-bit words from a valid/ready stream and emits them as one DSIZE*NSIZE-bit word on a valid/ready stream.
- It is the packing counterpart of data_pipe_nto1. A data_pipe_1ton feeding a data_pipe_nto1 with the same parameters must return the original narrow stream unchanged.
- Supports early group termination (wr_last), using a lane-keep mask.

Parameters:
- DSIZE, 4, width of one narrow input word.
- NSIZE, 2, narrow words per wide output word; legal values are 2 and above.
- MSB_FIRST, 1, lane order. 1: first accepted word lands in the top lane, rd_data[DSIZE*NSIZE-1 -: DSIZE]. 0: first word lands in rd_data[DSIZE-1:0].

Ports:
- clock  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- wr_data  in  DSIZE  narrow input word.
- wr_vld  in  1  wr_data is valid.
- wr_last  in  1  qualified by wr_vld; this word closes the current group early.
- wr_ready  out  1  block accepts the narrow word this cycle.
- rd_data  out  DSIZE*NSIZE  packed wide word.
- rd_vld  out  1  rd_data, rd_keep and rd_last are valid.
- rd_keep  out  NSIZE  bit i set means lane i holds real data. Lane i follows fill order: lane 0 is the first word.
- rd_last  out  1  the group was closed by wr_last.
- rd_ready  in  1  downstream consumes the wide word.

Behaviour:
- Interface: one clock, clock. rst is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: rd_vld=0, rd_data=0, rd_keep=0, rd_last=0, fill counter cnt=0, assembly register=0.
- wr_ready = !rd_vld || rd_ready.
  - This is a combinational path from rd_ready to wr_ready and is intentional.
  - During reset wr_ready may read 1, but nothing is accepted while rst=1.
- Accept: wr_vld && wr_ready at a rising edge.
  - The word is written into lane cnt of the assembly register.
  - cnt increments (cnt is $clog2(NSIZE) bits wide).
- Group completes when the accepted word has cnt==NSIZE-1 or wr_last=1. On completion, at the same edge:
  - The assembly register, including this word, is copied to the rd_data register.
  - rd_vld goes to 1.
  - rd_keep = mask of lanes 0..cnt.
  - rd_last = wr_last.
  - cnt returns to 0.
  - The assembly register clears to 0, so unused lanes of the next output are 0.
- Latency: rd_vld is visible in the cycle after the edge that accepted the completing word.
- Sustained throughput: one narrow word per clock while rd_ready=1, so one wide word every NSIZE clocks.
- Output hold: while rd_vld && !rd_ready, rd_data, rd_keep and rd_last stay stable and no input is accepted.
- Output release: rd_vld && rd_ready at an edge clears rd_vld, unless a new group completes at the same edge. In that case rd_vld stays 1 and the new word replaces the old one with no bubble.
- Full group: rd_keep is all ones. rd_last reflects wr_last on the final word.
- wr_last on the first word: rd_keep = lane 0 only. The other lanes are 0.
- Lane mapping by MSB_FIRST is applied when the word is written into the assembly register. rd_keep bit i always refers to fill-order lane i.
- rst during a partial group or a held output: all state is discarded, with no flush of partial data. Accepting resumes in the cycle after rst deasserts, with cnt=0.
- No overflow is possible by construction. No data may be lost or duplicated under any pattern of wr_vld or rd_ready.

Test Plan (DSIZE=4, NSIZE=2, MSB_FIRST=1 unless stated):
- Normal stream: 100 words counting down from 4'hF, wrapping, rd_ready=1 from cycle 10.
  - Expect 50 outputs: 8'hFE, 8'hDC, ... each with rd_keep=2'b11 and rd_last=0.
  - Wide outputs every 2 clocks once flowing, with no gaps.
- Back-pressure full: rd_ready=0, drive 30 words.
  - wr_ready drops after word 2 and holds. rd_data=8'hFE stays stable.
  - Raise rd_ready for 5 outputs: each release accepts further words, and outputs stay in order with no loss.
- Early last: words 4'hA, then 4'h5 with wr_last=1, then 4'h3 with wr_last=1.
  - Outputs: 8'hA5, keep 2'b11, last=1; then 8'h30, keep 2'b01, last=1.
- Underflow / partial: 3 words (4'hF, 4'hE, 4'hD), rd_ready=1 for 60 cycles.
  - Exactly one output, 8'hFE. rd_vld stays 0 afterwards; 4'hD remains pending in the assembly register.
- Reset mid-group: accept 4'h7, assert rst for 1 cycle, then send 4'h1, 4'h2.
  - Output is 8'h12. The 4'h7 never appears.
- MSB_FIRST=0, NSIZE=4: input words 1, 2, 3, 4.
  - rd_data=16'h4321, rd_keep=4'hF.
  - Feeding this into data_pipe_nto1 returns 1, 2, 3, 4.

Source files
------------

// File: rtl/data_pipe_1ton.sv
// Narrow-to-wide packer. NSIZE consecutive DSIZE-bit words are collected
// into one wide word. A group can be closed early with wr_last, and the
// lanes that hold real data are flagged in rd_keep.
module data_pipe_1ton #(
  parameter int unsigned DSIZE     = 4,
  parameter int unsigned NSIZE     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [DSIZE-1:0]       wr_data,
  input  logic                   wr_vld,
  input  logic                   wr_last,
  output logic                   wr_ready,
  output logic [DSIZE*NSIZE-1:0] rd_data,
  output logic                   rd_vld,
  output logic [NSIZE-1:0]       rd_keep,
  output logic                   rd_last,
  input  logic                   rd_ready
);

  localparam int unsigned      CW       = $clog2(NSIZE);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(NSIZE - 1);
  localparam logic [NSIZE-1:0] KEEP_ALL = '1;

  logic [CW-1:0]          cnt;
  logic [DSIZE*NSIZE-1:0] asm_q;
  logic [DSIZE*NSIZE-1:0] asm_next;
  logic [NSIZE-1:0]       keep_next;
  logic [CW-1:0]          lane;
  logic                   accept;
  logic                   done;

  // Output slot is free when empty or being drained in this same cycle.
  assign wr_ready  = !rd_vld || rd_ready;
  assign accept    = wr_vld && wr_ready;
  assign done      = (cnt == CNT_MAX) || wr_last;
  // Physical lane in the wide word for the word at fill position cnt.
  assign lane      = MSB_FIRST ? (CNT_MAX - cnt) : cnt;
  // Fill-order lanes 0..cnt are populated.
  assign keep_next = KEEP_ALL >> (CNT_MAX - cnt);

  // Assembly register with the incoming word merged into its lane.
  always_comb begin
    asm_next = asm_q;
    for (int unsigned l = 0; l < NSIZE; l++) begin
      if (l == 32'(lane)) begin
        asm_next[l*DSIZE +: DSIZE] = wr_data;
      end
    end
  end

  // Fill counter, assembly register and output register.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt     <= '0;
      asm_q   <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
      rd_keep <= '0;
      rd_last <= 1'b0;
    end else begin
      if (rd_vld && rd_ready) begin
        rd_vld <= 1'b0;
      end
      if (accept) begin
        if (done) begin
          // Completion overrides the release above, so a back-to-back
          // group replaces the old word without a bubble.
          rd_data <= asm_next;
          rd_vld  <= 1'b1;
          rd_keep <= keep_next;
          rd_last <= wr_last;
          cnt     <= '0;
          asm_q   <= '0;
        end else begin
          asm_q <= asm_next;
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_pipe_1ton.sv
// Bench for data_pipe_1ton: a 4x2 MSB-first instance checked against a
// queue-based packing model, plus a 4x4 LSB-first instance with a short
// directed sequence.
module tb_data_pipe_1ton;

  localparam int unsigned DW  = 4;
  localparam int unsigned NS  = 2;
  localparam bit          MSB = 1'b1;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DSIZE=4, NSIZE=2, MSB_FIRST=1
  logic          a_rst, a_wr_vld, a_wr_last, a_wr_ready, a_rd_vld, a_rd_last, a_rd_ready;
  logic [DW-1:0] a_wr_data;
  logic [7:0]    a_rd_data;
  logic [1:0]    a_rd_keep;

  data_pipe_1ton #(.DSIZE(DW), .NSIZE(NS), .MSB_FIRST(MSB)) dut_a (
    .clock(clk), .rst(a_rst), .wr_data(a_wr_data), .wr_vld(a_wr_vld),
    .wr_last(a_wr_last), .wr_ready(a_wr_ready), .rd_data(a_rd_data),
    .rd_vld(a_rd_vld), .rd_keep(a_rd_keep), .rd_last(a_rd_last),
    .rd_ready(a_rd_ready)
  );

  // Instance B: DSIZE=4, NSIZE=4, MSB_FIRST=0
  logic        b_rst, b_wr_vld, b_wr_last, b_wr_ready, b_rd_vld, b_rd_last, b_rd_ready;
  logic [3:0]  b_wr_data;
  logic [15:0] b_rd_data;
  logic [3:0]  b_rd_keep;

  data_pipe_1ton #(.DSIZE(4), .NSIZE(4), .MSB_FIRST(1'b0)) dut_b (
    .clock(clk), .rst(b_rst), .wr_data(b_wr_data), .wr_vld(b_wr_vld),
    .wr_last(b_wr_last), .wr_ready(b_wr_ready), .rd_data(b_rd_data),
    .rd_vld(b_rd_vld), .rd_keep(b_rd_keep), .rd_last(b_rd_last),
    .rd_ready(b_rd_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc    = 0;

  // Reference model state: pending output and words of the open group.
  bit            m_vld  = 1'b0;
  logic [7:0]    m_data = '0;
  logic [1:0]    m_keep = '0;
  bit            m_last = 1'b0;
  logic [DW-1:0] grp[$];

  // Outputs observed leaving DUT A (rd_vld && rd_ready before an edge).
  logic [7:0] cons_d[$];
  logic [1:0] cons_k[$];
  bit         cons_l[$];
  int         cons_c[$];

  typedef struct {
    bit         v;
    logic [3:0] d;
    bit         l;
    bit         r;
    bit         ev;
    logic [7:0] ed;
    logic [1:0] ek;
    bit         el;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_update(input bit v, input logic [3:0] d, input bit l,
                              input bit r, input bit rs);
    bit rdy;
    if (rs) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_keep = '0;
      m_last = 1'b0;
      grp.delete();
    end else begin
      rdy = !m_vld || r;
      if (m_vld && r) m_vld = 1'b0;
      if (v && rdy) begin
        acc++;
        grp.push_back(d);
        if (grp.size() == NS || l) begin
          m_data = '0;
          foreach (grp[k]) begin
            int pos;
            pos = MSB ? (NS - 1 - k) : k;
            m_data[pos*DW +: DW] = grp[k];
          end
          m_keep = 2'((1 << grp.size()) - 1);
          m_last = l;
          m_vld  = 1'b1;
          grp.delete();
        end
      end
    end
  endtask

  // One clock on instance A: drive at negedge, check, step model, sample at next negedge.
  task automatic step(input bit v, input logic [3:0] d, input bit l,
                      input bit r, input bit rs);
    a_wr_vld = v; a_wr_data = d; a_wr_last = l; a_rd_ready = r; a_rst = rs;
    #1;
    if (!rs) begin
      check("wr_ready", 32'(a_wr_ready), 32'(!m_vld || r));
      if (a_rd_vld && r) begin
        cons_d.push_back(a_rd_data);
        cons_k.push_back(a_rd_keep);
        cons_l.push_back(a_rd_last);
        cons_c.push_back(cyc);
      end
    end
    model_update(v, d, l, r, rs);
    @(negedge clk);
    cyc++;
    check("rd_vld", 32'(a_rd_vld), 32'(m_vld));
    if (m_vld) begin
      check("rd_data", 32'(a_rd_data), 32'(m_data));
      check("rd_keep", 32'(a_rd_keep), 32'(m_keep));
      check("rd_last", 32'(a_rd_last), 32'(m_last));
    end
  endtask

  task automatic reset_a();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cons_d.delete(); cons_k.delete(); cons_l.delete(); cons_c.delete();
  endtask

  // k-th wide word of a stream counting down from 4'hF.
  function automatic logic [7:0] exp_cd(input int k);
    logic [3:0] hi, lo;
    hi = 4'(15 - 2*k);
    lo = 4'(14 - 2*k);
    return {hi, lo};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int i;
    int prev;
    logic [15:0] bd;

    a_rst = 1'b1; a_wr_vld = 0; a_wr_data = '0; a_wr_last = 0; a_rd_ready = 0;
    b_rst = 1'b1; b_wr_vld = 0; b_wr_data = '0; b_wr_last = 0; b_rd_ready = 1;

    // ---- Instance B: LSB-first, 4 lanes ----
    @(negedge clk); @(negedge clk);
    check("b_reset_vld", 32'(b_rd_vld), 32'd0);
    b_rst = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      b_wr_vld = 1'b1; b_wr_data = 4'(w); b_wr_last = 1'b0;
      @(negedge clk);
      if (w == 3) check("b_vld_partial", 32'(b_rd_vld), 32'd0);
    end
    check("b_vld", 32'(b_rd_vld), 32'd1);
    check("b_data", 32'(b_rd_data), 32'h4321);
    check("b_keep", 32'(b_rd_keep), 32'hF);
    check("b_last", 32'(b_rd_last), 32'd0);
    bd = b_rd_data;
    for (int ln = 0; ln < 4; ln++) begin
      if (b_rd_keep[ln]) check("b_unpack", 32'(bd[ln*4 +: 4]), 32'(ln + 1));
    end
    b_wr_data = 4'h5; b_wr_last = 1'b1;
    @(negedge clk);
    check("b_early_vld", 32'(b_rd_vld), 32'd1);
    check("b_early_data", 32'(b_rd_data), 32'h0005);
    check("b_early_keep", 32'(b_rd_keep), 32'h1);
    check("b_early_last", 32'(b_rd_last), 32'd1);
    b_wr_vld = 1'b0; b_wr_last = 1'b0;
    @(negedge clk);
    check("b_drain_vld", 32'(b_rd_vld), 32'd0);

    // ---- Instance A: reset state ----
    reset_a();
    reset_a();
    check("reset_vld", 32'(a_rd_vld), 32'd0);
    check("reset_data", 32'(a_rd_data), 32'd0);
    check("reset_keep", 32'(a_rd_keep), 32'd0);
    check("reset_last", 32'(a_rd_last), 32'd0);

    // ---- Table: full groups, early last, hold and release ----
    tbl[0]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 8'hFE, 2'b11, 1'b0};
    tbl[2]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 8'hA5, 2'b11, 1'b1};
    tbl[4]  = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 8'h30, 2'b01, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[6]  = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 8'h70, 2'b01, 1'b1};
    tbl[7]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 8'h12, 2'b11, 1'b0};
    tbl[9]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 8'h12, 2'b11, 1'b0};
    tbl[10] = '{1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[11] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 8'h98, 2'b11, 1'b0};
    tbl[12] = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    tbl[13] = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 8'hCB, 2'b11, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0};
    reset_a();
    foreach (tbl[n]) begin
      step(tbl[n].v, tbl[n].d, tbl[n].l, tbl[n].r, 1'b0);
      check("tbl_vld", 32'(a_rd_vld), 32'(tbl[n].ev));
      if (tbl[n].ev) begin
        check("tbl_data", 32'(a_rd_data), 32'(tbl[n].ed));
        check("tbl_keep", 32'(a_rd_keep), 32'(tbl[n].ek));
        check("tbl_last", 32'(a_rd_last), 32'(tbl[n].el));
      end
    end

    // ---- Normal stream: 100 words, rd_ready from cycle 10 ----
    reset_a();
    i = 0;
    for (int c = 0; c < 400 && cons_d.size() < 50; c++) begin
      prev = acc;
      step(i < 100, 4'(15 - i), 1'b0, c >= 10, 1'b0);
      if (acc != prev) i++;
    end
    check("stream_count", 32'(cons_d.size()), 32'd50);
    foreach (cons_d[k]) begin
      check("stream_data", 32'(cons_d[k]), 32'(exp_cd(k)));
      check("stream_keep", 32'(cons_k[k]), 32'h3);
      check("stream_last", 32'(cons_l[k]), 32'd0);
      if (k > 0) check("stream_gap", 32'(cons_c[k] - cons_c[k-1]), 32'd2);
    end

    // ---- Back-pressure ----
    reset_a();
    i = 0;
    for (int c = 0; c < 12; c++) begin
      prev = acc;
      step(1'b1, 4'(15 - i), 1'b0, 1'b0, 1'b0);
      if (acc != prev) i++;
    end
    check("bp_accepted", 32'(i), 32'd2);
    check("bp_wr_ready", 32'(a_wr_ready), 32'd0);
    check("bp_hold_data", 32'(a_rd_data), 32'hFE);
    for (int c = 0; c < 100 && cons_d.size() < 5; c++) begin
      prev = acc;
      step(i < 30, 4'(15 - i), 1'b0, 1'b1, 1'b0);
      if (acc != prev) i++;
    end
    check("bp_count5", 32'(cons_d.size()), 32'd5);
    for (int c = 0; c < 400 && cons_d.size() < 15; c++) begin
      prev = acc;
      step(i < 30, 4'(15 - i), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (acc != prev) i++;
    end
    check("bp_count15", 32'(cons_d.size()), 32'd15);
    foreach (cons_d[k]) check("bp_data", 32'(cons_d[k]), 32'(exp_cd(k)));

    // ---- Partial group stays pending ----
    reset_a();
    step(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'hE, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 60; c++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("partial_count", 32'(cons_d.size()), 32'd1);
    if (cons_d.size() > 0) check("partial_data", 32'(cons_d[0]), 32'hFE);
    check("partial_idle", 32'(a_rd_vld), 32'd0);
    step(1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
    check("partial_resume", 32'(a_rd_data), 32'hDC);

    // ---- Reset mid-group ----
    reset_a();
    step(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("midrst_count", 32'(cons_d.size()), 32'd1);
    if (cons_d.size() > 0) check("midrst_data", 32'(cons_d[0]), 32'h12);

    // ---- Random traffic against the model ----
    reset_a();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 70, 4'($urandom), $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
